data_stack: RTL and testbench

Operand stack that executes the per-instruction `stackOP` / `stackControl` commands issued by the control unit. Each cycle it updates the stack according to the command: push, pop, pop-two, pop-and-replace or swap. The top two entries are exposed continuously as the ALU A/B operands, and the top entry also feeds the PC (for `js`) and memory write data. Overflow and underflow are detected; an illegal operation is suppressed and reported through a sticky error flag.

---
 rtl/stack_pkg.sv | 25 ++
 rtl/lifo_ram.sv | 41 ++++
 rtl/data_stack.sv | 143 ++++++++++++++
 tb/tb_data_stack.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared constants for the operand and return stacks. This file holds the command
// encodings, the data-source encodings and the default word/depth sizes.
package stack_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int DEPTH_DEFAULT = 16;

    typedef enum logic [2:0] {
        OP_NONE          = 3'd0,
        OP_PUSH          = 3'd1,
        OP_POPANDREPLACE = 3'd2,
        OP_POP           = 3'd3,
        OP_POP2          = 3'd4,
        OP_SWAP          = 3'd5
    } stack_op_e;

    typedef enum logic [2:0] {
        SRC_IMM    = 3'd0,
        SRC_IMMLUI = 3'd1,
        SRC_MEM    = 3'd2,
        SRC_ALU    = 3'd3,
        SRC_INPUT  = 3'd4
    } stack_src_e;

endpackage

// File: rtl/lifo_ram.sv
// Register-array LIFO for the stack entries below the two top registers.
// It has a synchronous write and combinational reads of the two most recent entries.
module lifo_ram #(
    parameter int WIDTH   = stack_pkg::WIDTH_DEFAULT,
    parameter int ENTRIES = stack_pkg::DEPTH_DEFAULT - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [1:0]       pop_n,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] second
);
    // A zero-entry configuration still needs one slot so the array stays legal.
    localparam int SLOTS = (ENTRIES < 1) ? 1 : ENTRIES;
    localparam int PW    = $clog2(SLOTS + 1);

    logic [WIDTH-1:0] mem [SLOTS];
    logic [PW-1:0]    ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (push) begin
            ptr <= ptr + 1'b1;
        end else begin
            ptr <= ptr - PW'(pop_n);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= wr_data;
        end
    end

    assign head   = (ptr >= PW'(1)) ? mem[ptr - PW'(1)] : '0;
    assign second = (ptr >= PW'(2)) ? mem[ptr - PW'(2)] : '0;

endmodule

// File: rtl/data_stack.sv
// Operand stack: top/next live in registers and deeper entries live in lifo_ram.
// Illegal commands are dropped and recorded in the sticky overflow/underflow flags.
module data_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic [2:0]                 stackOP,
    input  logic [2:0]                 stackControl,
    input  logic [11:0]                imm,
    input  logic [WIDTH-1:0]           alu_result,
    input  logic [WIDTH-1:0]           mem_data,
    input  logic [WIDTH-1:0]           in_data,
    output logic [WIDTH-1:0]           top,
    output logic [WIDTH-1:0]           next,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] top_q, next_q, top_d, next_d, src;
    logic [WIDTH-1:0] lifo_head, lifo_second;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, udf_q, ovf_set, udf_set;
    logic             lifo_push;
    logic [1:0]       lifo_pop;

    always_comb begin
        src = '0;
        case (stackControl)
            SRC_IMM:    src = {{(WIDTH-12){imm[11]}}, imm};
            SRC_IMMLUI: src[15:0] = {imm[7:0], 8'h00};
            SRC_MEM:    src = mem_data;
            SRC_ALU:    src = alu_result;
            SRC_INPUT:  src = in_data;
            default:    src = '0;
        endcase
    end

    // lifo_ram holds count-2 entries, so it is only touched once count passes 2.
    always_comb begin
        top_d     = top_q;
        next_d    = next_q;
        count_d   = count_q;
        ovf_set   = 1'b0;
        udf_set   = 1'b0;
        lifo_push = 1'b0;
        lifo_pop  = 2'd0;
        case (stackOP)
            OP_PUSH: begin
                if (count_q < FULL) begin
                    top_d     = src;
                    next_d    = top_q;
                    lifo_push = (count_q >= CW'(2));
                    count_d   = count_q + 1'b1;
                end else begin
                    ovf_set = 1'b1;
                end
            end
            OP_POPANDREPLACE: begin
                if (count_q >= CW'(2)) begin
                    top_d    = src;
                    next_d   = lifo_head;
                    lifo_pop = (count_q >= CW'(3)) ? 2'd1 : 2'd0;
                    count_d  = count_q - 1'b1;
                end else begin
                    udf_set = 1'b1;
                end
            end
            OP_POP: begin
                if (count_q >= CW'(1)) begin
                    top_d    = next_q;
                    next_d   = lifo_head;
                    lifo_pop = (count_q >= CW'(3)) ? 2'd1 : 2'd0;
                    count_d  = count_q - 1'b1;
                end else begin
                    udf_set = 1'b1;
                end
            end
            OP_POP2: begin
                if (count_q >= CW'(2)) begin
                    top_d    = lifo_head;
                    next_d   = lifo_second;
                    lifo_pop = (count_q >= CW'(4)) ? 2'd2 :
                               (count_q == CW'(3)) ? 2'd1 : 2'd0;
                    count_d  = count_q - CW'(2);
                end else begin
                    udf_set = 1'b1;
                end
            end
            OP_SWAP: begin
                if (count_q >= CW'(2)) begin
                    top_d  = next_q;
                    next_d = top_q;
                end else begin
                    udf_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            top_q   <= '0;
            next_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            next_q  <= next_d;
            count_q <= count_d;
            ovf_q   <= ovf_q | ovf_set;
            udf_q   <= udf_q | udf_set;
        end
    end

    lifo_ram #(
        .WIDTH   (WIDTH),
        .ENTRIES (DEPTH - 2)
    ) u_lifo (
        .clk     (CLK),
        .rst_n   (reset),
        .push    (lifo_push),
        .pop_n   (lifo_pop),
        .wr_data (next_q),
        .head    (lifo_head),
        .second  (lifo_second)
    );

    assign top       = (count_q >= CW'(1)) ? top_q  : '0;
    assign next      = (count_q >= CW'(2)) ? next_q : '0;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_data_stack.sv
// Directed bench for data_stack: one task per scenario with hand-computed expectations.
module tb_data_stack;
    import stack_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;

    logic             CLK = 1'b0;
    logic             reset = 1'b0;
    logic [2:0]       stackOP = 3'd0;
    logic [2:0]       stackControl = 3'd0;
    logic [11:0]      imm = '0;
    logic [WIDTH-1:0] alu_result = '0;
    logic [WIDTH-1:0] mem_data = '0;
    logic [WIDTH-1:0] in_data = '0;
    logic [WIDTH-1:0] top, next;
    logic [4:0]       count;
    logic             overflow, underflow;

    int checks = 0;
    int errors = 0;

    data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .stackOP      (stackOP),
        .stackControl (stackControl),
        .imm          (imm),
        .alu_result   (alu_result),
        .mem_data     (mem_data),
        .in_data      (in_data),
        .top          (top),
        .next         (next),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 CLK = ~CLK;

    task automatic apply_reset();
        stackOP = 3'd0;
        reset   = 1'b0;
        @(posedge CLK);
        #1;
        reset = 1'b1;
    endtask

    // Applies one command for one edge; outputs are stable #1 after that edge.
    task automatic do_op(input logic [2:0] op, input logic [2:0] ctl,
                         input logic [11:0] im, input logic [WIDTH-1:0] alu);
        stackOP      = op;
        stackControl = ctl;
        imm          = im;
        alu_result   = alu;
        @(posedge CLK);
        #1;
        stackOP = 3'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++;
        if ({top, next, count, overflow, underflow} !== '0) begin
            errors++;
            $display("FAIL reset_state: got top=%h next=%h count=%0d ovf=%b udf=%b, expected all 0",
                     top, next, count, overflow, underflow);
        end
        apply_reset();
    endtask

    task automatic test_pushes();
        apply_reset();
        do_op(OP_PUSH, SRC_IMM, 12'hFFF, '0);
        checks++;
        if (top !== 16'hFFFF || count !== 5'd1) begin
            errors++;
            $display("FAIL push_imm_sext: got top=%h count=%0d, expected ffff 1", top, count);
        end
        do_op(OP_PUSH, SRC_IMMLUI, 12'h012, '0);
        checks++;
        if (top !== 16'h1200 || next !== 16'hFFFF || count !== 5'd2 ||
            overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL push_lui: got top=%h next=%h count=%0d ovf=%b udf=%b, expected 1200 ffff 2 0 0",
                     top, next, count, overflow, underflow);
        end
    endtask

    task automatic test_replace_swap();
        apply_reset();
        do_op(OP_PUSH, SRC_IMM, 12'd3, '0);
        do_op(OP_PUSH, SRC_IMM, 12'd5, '0);
        do_op(OP_POPANDREPLACE, SRC_ALU, '0, 16'd8);
        checks++;
        if (top !== 16'd8 || next !== 16'd0 || count !== 5'd1) begin
            errors++;
            $display("FAIL replace_alu: got top=%h next=%h count=%0d, expected 8 0 1", top, next, count);
        end
        do_op(OP_PUSH, SRC_IMM, 12'd1, '0);
        do_op(OP_SWAP, SRC_IMM, '0, '0);
        checks++;
        if (top !== 16'd8 || next !== 16'd1 || count !== 5'd2 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL swap: got top=%h next=%h count=%0d udf=%b, expected 8 1 2 0",
                     top, next, count, underflow);
        end
    endtask

    task automatic test_deep_ops();
        apply_reset();
        do_op(OP_PUSH, SRC_IMM, 12'd10, '0);
        do_op(OP_PUSH, SRC_IMM, 12'd20, '0);
        do_op(OP_PUSH, SRC_IMM, 12'd30, '0);
        do_op(OP_PUSH, SRC_IMM, 12'd40, '0);
        do_op(OP_POPANDREPLACE, SRC_ALU, '0, 16'd70);
        checks++;
        if (top !== 16'd70 || next !== 16'd20 || count !== 5'd3) begin
            errors++;
            $display("FAIL replace_deep: got top=%0d next=%0d count=%0d, expected 70 20 3", top, next, count);
        end
        do_op(OP_PUSH, SRC_IMM, 12'd50, '0);
        do_op(OP_POP2, SRC_IMM, '0, '0);
        checks++;
        if (top !== 16'd20 || next !== 16'd10 || count !== 5'd2) begin
            errors++;
            $display("FAIL pop2_deep: got top=%0d next=%0d count=%0d, expected 20 10 2", top, next, count);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) do_op(OP_PUSH, SRC_IMM, 12'(i), '0);
        checks++;
        if (count !== 5'd16 || top !== 16'd15 || next !== 16'd14 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill: got count=%0d top=%0d next=%0d ovf=%b, expected 16 15 14 0",
                     count, top, next, overflow);
        end
        do_op(OP_PUSH, SRC_IMM, 12'd99, '0);
        checks++;
        if (count !== 5'd16 || top !== 16'd15 || overflow !== 1'b1 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow: got count=%0d top=%0d ovf=%b udf=%b, expected 16 15 1 0",
                     count, top, overflow, underflow);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (top !== 16'(15 - i) || count !== 5'(16 - i)) begin
                errors++;
                $display("FAIL drain_%0d: got top=%0d count=%0d, expected %0d %0d",
                         i, top, count, 15 - i, 16 - i);
            end
            do_op(OP_POP, SRC_IMM, '0, '0);
        end
        checks++;
        if (count !== 5'd0 || top !== 16'd0 || underflow !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL drained: got count=%0d top=%0d udf=%b ovf=%b, expected 0 0 0 1",
                     count, top, underflow, overflow);
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        do_op(OP_PUSH, SRC_IMM, 12'd4, '0);
        do_op(OP_POP2, SRC_IMM, '0, '0);
        checks++;
        if (count !== 5'd1 || top !== 16'd4 || underflow !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL pop2_at_1: got count=%0d top=%0d udf=%b ovf=%b, expected 1 4 1 0",
                     count, top, underflow, overflow);
        end
        do_op(OP_POP, SRC_IMM, '0, '0);
        checks++;
        if (count !== 5'd0 || top !== 16'd0 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL pop_at_1: got count=%0d top=%0d udf=%b, expected 0 0 1", count, top, underflow);
        end
        do_op(OP_POP, SRC_IMM, '0, '0);
        checks++;
        if (count !== 5'd0 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL pop_at_0: got count=%0d udf=%b, expected 0 1", count, underflow);
        end
        apply_reset();
        do_op(OP_SWAP, SRC_IMM, '0, '0);
        checks++;
        if (count !== 5'd0 || underflow !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL swap_at_0: got count=%0d udf=%b ovf=%b, expected 0 1 0", count, underflow, overflow);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        mem_data = 16'hA5A5;
        do_op(OP_PUSH, SRC_MEM, '0, '0);
        do_op(OP_PUSH, SRC_MEM, '0, '0);
        checks++;
        if (top !== 16'hA5A5 || next !== 16'hA5A5 || count !== 5'd2) begin
            errors++;
            $display("FAIL push_mem: got top=%h next=%h count=%0d, expected a5a5 a5a5 2", top, next, count);
        end
        stackOP      = OP_PUSH;
        stackControl = SRC_MEM;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({top, next, count, overflow, underflow} !== '0) begin
            errors++;
            $display("FAIL async_reset: got top=%h next=%h count=%0d ovf=%b udf=%b, expected all 0",
                     top, next, count, overflow, underflow);
        end
        stackOP = OP_NONE;
        @(posedge CLK);
        #1;
        reset   = 1'b1;
        in_data = 16'd7;
        do_op(OP_PUSH, SRC_INPUT, '0, '0);
        checks++;
        if (top !== 16'd7 || count !== 5'd1 || next !== 16'd0) begin
            errors++;
            $display("FAIL push_input: got top=%h next=%h count=%0d, expected 7 0 1", top, next, count);
        end
    endtask

    task automatic test_invalid_codes();
        apply_reset();
        do_op(OP_PUSH, SRC_IMM, 12'd2, '0);
        do_op(3'd6, SRC_IMM, 12'd9, '0);
        do_op(3'd7, SRC_IMM, 12'd9, '0);
        checks++;
        if (top !== 16'd2 || count !== 5'd1 || underflow !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL op_6_7: got top=%0d count=%0d udf=%b ovf=%b, expected 2 1 0 0",
                     top, count, underflow, overflow);
        end
        do_op(OP_PUSH, 3'd6, 12'h7FF, 16'h1234);
        checks++;
        if (top !== 16'd0 || next !== 16'd2 || count !== 5'd2) begin
            errors++;
            $display("FAIL src_6: got top=%h next=%h count=%0d, expected 0 2 2", top, next, count);
        end
    endtask

    initial begin
        test_reset();
        test_pushes();
        test_replace_swap();
        test_deep_ops();
        test_overflow();
        test_underflow();
        test_reset_mid();
        test_invalid_codes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
